// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit with HI/LO registers and D-stage stall request.
// Optional feature: define MDU_CANCEL_EN to let md_cancel abort an in-flight op.
module mult_div_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdstart,
  input  logic [2:0]  mdop,
  input  logic        hlwrite,
  input  logic        hlsel,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        d_md_use,
  input  logic        md_cancel,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hlout
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MUL_N = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   hi;
  logic [31:0]   lo;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic          pend_wr;

  logic          cancel;
  logic          go;
  logic          mt;
  logic [63:0]   prod;
  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;
  logic          res_wr;

`ifdef MDU_CANCEL_EN
  assign cancel = md_cancel;
`else
  logic unused_cancel;
  assign unused_cancel = md_cancel;
  assign cancel = 1'b0;
`endif

  assign sa = $signed(srcA);
  assign sb = $signed(srcB);

  // Only 000..011 are real operations; mdstart always blocks an mt write.
  assign go = mdstart & ~busy & ~mdop[2] & ~cancel;
  assign mt = hlwrite & ~busy & ~mdstart & ~cancel;

  assign hlout    = hlsel ? lo : hi;
  assign md_stall = d_md_use & (mdstart | busy);

  // Result of the operation being started, latched into the pending regs.
  always_comb begin
    prod   = '0;
    res_hi = '0;
    res_lo = '0;
    res_wr = 1'b1;
    unique case (mdop[1:0])
      2'b00: begin
        prod = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      2'b01: begin
        prod = {32'b0, srcA} * {32'b0, srcB};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      2'b10: begin
        if (srcB == 32'h0) begin
          res_wr = 1'b0;
        end else if (srcA == 32'h8000_0000 && srcB == 32'hFFFF_FFFF) begin
          res_lo = 32'h8000_0000;
          res_hi = 32'h0;
        end else begin
          res_lo = $unsigned(sa / sb);
          res_hi = $unsigned(sa % sb);
        end
      end
      2'b11: begin
        if (srcB == 32'h0) begin
          res_wr = 1'b0;
        end else begin
          res_lo = srcA / srcB;
          res_hi = srcA % srcB;
        end
      end
    endcase
  end

  // Busy sequencing, pending result commit and mthi/mtlo writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else if (cancel) begin
      state   <= IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      pend_wr <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            state   <= RUN;
            busy    <= 1'b1;
            cnt     <= mdop[1] ? DIV_N : MUL_N;
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_wr <= res_wr;
          end else if (mt) begin
            if (hlsel) lo <= srcA;
            else       hi <= srcA;
          end
        end
        RUN: begin
          if (cnt == ONE) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            pend_wr <= 1'b0;
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed scenarios plus random traffic
// checked every cycle against a transaction-level HI/LO model.
module tb_mult_div_unit;

  localparam int MUL = 5;
  localparam int DIV = 10;
`ifdef MDU_CANCEL_EN
  localparam bit CAN = 1'b1;
`else
  localparam bit CAN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, mdstart, hlwrite, hlsel, d_md_use, md_cancel;
  logic [2:0]  mdop;
  logic [31:0] srcA, srcB;
  logic        busy, md_stall;
  logic [31:0] hlout;

  int n_cmp = 0;
  int n_bad = 0;
  int stall_cnt = 0;

  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_pv;
  int          m_now, m_start, m_until;

  mult_div_unit #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
    .clk(clk), .reset(reset), .mdstart(mdstart), .mdop(mdop),
    .hlwrite(hlwrite), .hlsel(hlsel), .srcA(srcA), .srcB(srcB),
    .d_md_use(d_md_use), .md_cancel(md_cancel),
    .busy(busy), .md_stall(md_stall), .hlout(hlout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_busy();
    return (m_now > m_start) && (m_now <= m_until);
  endfunction

  // Architectural result of one md op, from plain 64-bit arithmetic.
  task automatic ref_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output bit wr,
                        output logic [31:0] rh, output logic [31:0] rl);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    wr = 1'b1;
    rh = '0;
    rl = '0;
    case (op)
      3'd0: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
      3'd1: begin p = ua * ub; rh = p[63:32]; rl = p[31:0]; end
      3'd2: begin
        if (b == 0) wr = 1'b0;
        else begin
          q = sa / sb; r = sa % sb;
          rl = q[31:0]; rh = r[31:0];
        end
      end
      default: begin
        if (b == 0) wr = 1'b0;
        else begin
          uq = ua / ub; ur = ua % ub;
          rl = uq[31:0]; rh = ur[31:0];
        end
      end
    endcase
  endtask

  task automatic model_step();
    bit mb;
    mb = m_busy();
    if (reset) begin
      m_hi = '0; m_lo = '0; m_pv = 1'b0;
      m_start = -1; m_until = -1;
    end else if (CAN && md_cancel) begin
      m_until = -1; m_pv = 1'b0;
    end else begin
      if (mb && m_now == m_until) begin
        if (m_pv) begin m_hi = m_phi; m_lo = m_plo; end
        m_pv = 1'b0;
      end
      if (mdstart && !mb && mdop < 3'd4) begin
        m_start = m_now;
        m_until = m_now + (mdop[1] ? DIV : MUL);
        ref_op(mdop, srcA, srcB, m_pv, m_phi, m_plo);
      end else if (hlwrite && !mb && !mdstart) begin
        if (hlsel) m_lo = srcA;
        else       m_hi = srcA;
      end
    end
    m_now++;
  endtask

  task automatic tick();
    bit mb;
    @(negedge clk);
    mb = m_busy();
    check("busy", 32'(busy), 32'(mb));
    check("md_stall", 32'(md_stall), 32'(d_md_use & (mdstart | mb)));
    check("hlout", hlout, hlsel ? m_lo : m_hi);
    if (md_stall) stall_cnt++;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    reset = 0; mdstart = 0; hlwrite = 0; md_cancel = 0;
    mdop = 0; srcA = 0; srcB = 0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int n);
    int c;
    mdstart = 1; mdop = op; srcA = a; srcB = b;
    tick();
    idle();
    c = 0;
    while (busy && c < 40) begin
      tick();
      c++;
    end
    check(tag, 32'(c), 32'(n));
  endtask

  task automatic rd(input string tag, input logic [31:0] eh,
                    input logic [31:0] el);
    idle();
    hlsel = 0; #1 check({tag, "_hi"}, hlout, eh);
    hlsel = 1; #1 check({tag, "_lo"}, hlout, el);
    tick();
  endtask

  task automatic mt(input bit sel, input logic [31:0] v);
    idle(); hlwrite = 1; hlsel = sel; srcA = v;
    tick();
    idle();
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'(int'($urandom_range(0, 20)) - 10);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int c;
    idle(); d_md_use = 0; hlsel = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    m_now = 0; m_start = -1; m_until = -1; m_pv = 0;
    m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0;
    tick();
    idle();
    rd("reset", 32'h0, 32'h0);

    run_op("mult_lat", 3'd0, 32'hFFFF_FFFE, 32'd3, MUL);
    rd("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu_lat", 3'd1, 32'hFFFF_FFFE, 32'd3, MUL);
    rd("multu", 32'h2, 32'hFFFF_FFFA);
    run_op("div_lat", 3'd2, 32'hFFFF_FFF9, 32'd2, DIV);
    rd("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu0_lat", 3'd3, 32'd7, 32'd0, DIV);
    rd("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("ovf_lat", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV);
    rd("ovf", 32'h0, 32'h8000_0000);

    stall_cnt = 0;
    d_md_use = 1; hlsel = 1;
    run_op("stall_lat", 3'd0, 32'd6, 32'd7, MUL);
    tick();
    check("stall_cycles", 32'(stall_cnt), 32'd6);
    #1 check("mflo_new", hlout, 32'd42);
    d_md_use = 0;
    rd("after_stall", 32'h0, 32'd42);

    mt(1'b0, 32'h1234_5678);
    rd("mthi", 32'h1234_5678, 32'd42);
    mdstart = 1; hlwrite = 1; mdop = 3'd1; srcA = 32'd3; srcB = 32'd5;
    hlsel = 0;
    tick();
    idle();
    c = 0;
    while (busy && c < 40) begin tick(); c++; end
    rd("start_wins", 32'h0, 32'd15);
    mdstart = 1; mdop = 3'd5; srcA = 32'd9; srcB = 32'd9;
    tick();
    idle();
    check("badop_busy", 32'(busy), 32'd0);

    mdstart = 1; mdop = 3'd2; srcA = 32'd100; srcB = 32'd7;
    tick();
    idle();
    tick(); tick();
    reset = 1;
    tick();
    reset = 0;
    check("rst_busy", 32'(busy), 32'd0);
    rd("rst_mid", 32'h0, 32'h0);

    mt(1'b0, 32'hAAAA);
    mt(1'b1, 32'h5555);
    mdstart = 1; mdop = 3'd2; srcA = 32'd100; srcB = 32'd7;
    tick();
    idle();
    repeat (3) tick();
    md_cancel = 1;
    tick();
    md_cancel = 0;
    if (CAN) begin
      check("cancel_busy", 32'(busy), 32'd0);
      rd("cancel", 32'hAAAA, 32'h5555);
    end else begin
      c = 0;
      while (busy && c < 40) begin tick(); c++; end
      check("nocancel_len", 32'(c), 32'd6);
      rd("nocancel", 32'd2, 32'd14);
    end

    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      mdstart   = ($urandom_range(0, 3) == 0);
      mdop      = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7))
                                              : 3'($urandom_range(0, 3));
      hlwrite   = ($urandom_range(0, 4) == 0);
      hlsel     = 1'($urandom_range(0, 1));
      d_md_use  = 1'($urandom_range(0, 1));
      md_cancel = ($urandom_range(0, 29) == 0);
      srcA      = rnd32();
      srcB      = rnd32();
      tick();
    end

    idle(); d_md_use = 0;
    c = 0;
    while (busy && c < 40) begin tick(); c++; end
    check("final_idle", 32'(busy), 32'd0);
    rd("final", m_hi, m_lo);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
